// File: rtl/sr_ff_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sr_ff_sequencer
// Purpose  : Command-driven controller for a bank of external clocked SR
//            flip-flops. Pulses S or R on one bit, waits for the bank to
//            settle, reads Q back and reports the result. S and R are never
//            high together on any bit.
// Revision : 1.0 - initial release
// ============================================================================
module sr_ff_sequencer #(
   parameter int NUM_FF        = 4,
   parameter int IDX_W         = 2,
   parameter int PULSE_CYCLES  = 2,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [IDX_W-1:0]  cmd_idx,
   output logic [NUM_FF-1:0] S,
   output logic [NUM_FF-1:0] R,
   input  logic [NUM_FF-1:0] Q,
   output logic              busy,
   output logic              rsp_valid,
   output logic              rsp_q,
   output logic              rsp_err
);

   localparam int c_cnt_max = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
   localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

   localparam logic [c_cnt_w-1:0] c_pulse_load  = c_cnt_w'(PULSE_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_settle_load = c_cnt_w'(SETTLE_CYCLES - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);
   localparam logic [IDX_W:0]     c_num_ff      = (IDX_W + 1)'(NUM_FF);

   localparam logic [1:0] c_op_read   = 2'b00;
   localparam logic [1:0] c_op_set    = 2'b01;
   localparam logic [1:0] c_op_toggle = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRIVE  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_CHECK  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [c_cnt_w-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 set_q, set_d;     // 1: drive S / expect 1, 0: drive R / expect 0
   logic                 rd_q, rd_d;       // read command: no drive, no mismatch check
   logic                 oor_q, oor_d;     // index outside the bank
   logic [NUM_FF-1:0]    s_q, s_d, r_q, r_d;
   logic                 busy_q, busy_d;
   logic                 rsp_valid_q, rsp_valid_d;
   logic                 rsp_q_q, rsp_q_d;
   logic                 rsp_err_q, rsp_err_d;

   logic                 w_accept;
   logic                 w_in_range;
   logic                 w_q_bit;

   // Q bit at a given index; indices beyond the bank read as 0.
   function automatic logic bit_at(input logic [NUM_FF-1:0] v, input logic [IDX_W-1:0] ix);
      logic b;
      b = 1'b0;
      for (int i = 0; i < NUM_FF; i++) begin
         if (ix == IDX_W'(i)) b = v[i];
      end
      return b;
   endfunction

   // One-hot select of a bank bit; an out-of-range index selects nothing.
   function automatic logic [NUM_FF-1:0] one_hot(input logic [IDX_W-1:0] ix);
      logic [NUM_FF-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_FF; i++) begin
         if (ix == IDX_W'(i)) v[i] = 1'b1;
      end
      return v;
   endfunction

   assign cmd_ready  = (state_q == ST_IDLE) && !rst;
   assign w_accept   = cmd_valid && cmd_ready;
   assign w_in_range = {1'b0, cmd_idx} < c_num_ff;

   // Next-state logic and next values of the registered outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      set_d       = set_q;
      rd_d        = rd_q;
      oor_d       = oor_q;
      s_d         = '0;
      r_d         = '0;
      rsp_valid_d = 1'b0;
      rsp_q_d     = 1'b0;
      rsp_err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               idx_d = cmd_idx;
               // Toggle chooses its direction from Q as sampled at the accept edge.
               set_d = (cmd_op == c_op_set) ||
                       ((cmd_op == c_op_toggle) && !bit_at(Q, cmd_idx));
               rd_d  = (cmd_op == c_op_read);
               oor_d = !w_in_range;
               if (!w_in_range || (cmd_op == c_op_read)) begin
                  state_d = ST_CHECK;
               end else begin
                  state_d = ST_DRIVE;
                  cnt_d   = c_pulse_load;
               end
            end
         end
         ST_DRIVE: begin
            if (cnt_q == '0) begin
               state_d = ST_SETTLE;
               cnt_d   = c_settle_load;
            end else begin
               cnt_d = cnt_q - c_cnt_one;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               state_d = ST_CHECK;
            end else begin
               cnt_d = cnt_q - c_cnt_one;
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs are registered, so they are derived from the state being entered.
      w_q_bit = bit_at(Q, idx_d);
      if (state_d == ST_DRIVE) begin
         if (set_d) s_d = one_hot(idx_d);
         else       r_d = one_hot(idx_d);
      end
      if (state_d == ST_CHECK) begin
         rsp_valid_d = 1'b1;
         rsp_q_d     = !oor_d && w_q_bit;
         rsp_err_d   = oor_d || (!rd_d && (w_q_bit != set_d));
      end
      busy_d = (state_d != ST_IDLE);
   end

   // State, command context and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         set_q       <= 1'b0;
         rd_q        <= 1'b0;
         oor_q       <= 1'b0;
         s_q         <= '0;
         r_q         <= '0;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_q_q     <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         set_q       <= set_d;
         rd_q        <= rd_d;
         oor_q       <= oor_d;
         s_q         <= s_d;
         r_q         <= r_d;
         busy_q      <= busy_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_q_q     <= rsp_q_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign S         = s_q;
   assign R         = r_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_q     = rsp_q_q;
   assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_sr_ff_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sr_ff_sequencer
// Purpose  : Self-checking bench for sr_ff_sequencer with an SR flip-flop
//            bank model, a response scoreboard and per-cycle S/R checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_ff_sequencer;

   localparam int NUM_FF  = 4;
   localparam int IDX_W   = 2;
   localparam int PULSE   = 2;
   localparam int SETTLE  = 1;
   localparam int LAT_DRV = PULSE + SETTLE + 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [IDX_W-1:0]  cmd_idx;
   logic [NUM_FF-1:0] S, R, Q;
   logic              busy, rsp_valid, rsp_q, rsp_err;

   // Second instance with a 3-bit bank for the out-of-range index case.
   logic       v2, ready2, busy2, rv2, rq2, re2;
   logic [1:0] op2, idx2;
   logic [2:0] S2, R2, Q2;

   sr_ff_sequencer #(.NUM_FF(NUM_FF), .IDX_W(IDX_W), .PULSE_CYCLES(PULSE), .SETTLE_CYCLES(SETTLE)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_idx(cmd_idx), .S(S), .R(R), .Q(Q),
      .busy(busy), .rsp_valid(rsp_valid), .rsp_q(rsp_q), .rsp_err(rsp_err)
   );

   sr_ff_sequencer #(.NUM_FF(3), .IDX_W(2), .PULSE_CYCLES(PULSE), .SETTLE_CYCLES(SETTLE)) u_dut_oor (
      .clk(clk), .rst(rst), .cmd_valid(v2), .cmd_ready(ready2),
      .cmd_op(op2), .cmd_idx(idx2), .S(S2), .R(R2), .Q(Q2),
      .busy(busy2), .rsp_valid(rv2), .rsp_q(rq2), .rsp_err(re2)
   );

   // External SR flip-flop bank; stuck0 forces a Q bit low.
   logic [NUM_FF-1:0] ff_q   = '0;
   logic [NUM_FF-1:0] stuck0 = '0;
   assign Q = ff_q & ~stuck0;
   always @(posedge clk) begin
      for (int i = 0; i < NUM_FF; i++) begin
         if (S[i])      ff_q[i] <= 1'b1;
         else if (R[i]) ff_q[i] <= 1'b0;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   typedef struct {
      int   due;
      logic q;
      logic err;
   } exp_t;
   exp_t sb[$];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int                drv_from = 1, drv_to = 0, busy_to = -1;
   logic [NUM_FF-1:0] drv_s = '0, drv_r = '0;
   bit                mon_en = 1'b0, acc_seen = 1'b0;
   int                n_acc = 0, n_rsp = 0;

   // Per-cycle monitor: S/R pattern, invariants, busy/ready, responses, accepts.
   always @(negedge clk) begin
      logic              in_win, eb, ery, dset;
      logic [NUM_FF-1:0] es, er, one;
      exp_t              e;
      if (mon_en) begin
         in_win = (cyc >= drv_from) && (cyc <= drv_to);
         es = in_win ? drv_s : '0;
         er = in_win ? drv_r : '0;
         check_eq("S", S, es);
         check_eq("R", R, er);
         check_eq("invariants", {(|(S & R)), ($countones(S | R) > 1), (!in_win && (|(S | R)))}, 0);
         eb  = (cyc <= busy_to);
         ery = !rst && !eb;
         check_eq("busy", busy, eb);
         check_eq("cmd_ready", cmd_ready, ery);
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            n_rsp++;
            check_eq("rsp_valid", rsp_valid, 1);
            check_eq("rsp_q", rsp_q, e.q);
            check_eq("rsp_err", rsp_err, e.err);
         end else begin
            check_eq("rsp_valid_quiet", rsp_valid, 0);
         end
         acc_seen = 1'b0;
         if (rst) begin
            drv_to  = cyc;
            busy_to = cyc;
            sb.delete();
         end else if (cmd_valid && ery) begin
            acc_seen = 1'b1;
            n_acc++;
            if (cmd_op == 2'b00) begin
               e.due   = cyc + 1;
               e.q     = Q[cmd_idx];
               e.err   = 1'b0;
               busy_to = cyc + 1;
            end else begin
               dset     = (cmd_op == 2'b01) || ((cmd_op == 2'b11) && !Q[cmd_idx]);
               one      = '0;
               one[cmd_idx] = 1'b1;
               drv_from = cyc + 1;
               drv_to   = cyc + PULSE;
               drv_s    = dset ? one : '0;
               drv_r    = dset ? '0 : one;
               e.q      = dset && !stuck0[cmd_idx];
               e.err    = (e.q != dset);
               e.due    = cyc + LAT_DRV;
               busy_to  = e.due;
            end
            sb.push_back(e);
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [1:0] idx);
      @(posedge clk);
      #1;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_idx   = idx;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         if (acc_seen) break;
      end
      check_eq("accept", acc_seen, 1);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 100; k++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0 && cyc > busy_to) break;
      end
      check_eq("idle", (sb.size() == 0 && cyc > busy_to), 1);
   endtask

   int acc0, rsp0;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_idx = '0;
      v2 = 1'b0; op2 = 2'b00; idx2 = 2'd0; Q2 = 3'b111;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_S", S, 0);
      check_eq("rst_R", R, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rsp", {rsp_valid, rsp_q, rsp_err}, 0);
      check_eq("rst_ready", cmd_ready, 0);
      check_eq("rst_ready2", ready2, 0);
      mon_en = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;

      // Set idx 2
      send(2'b01, 2'd2);
      wait_idle();
      // Toggle idx 1 twice: first sets, second resets
      send(2'b11, 2'd1);
      wait_idle();
      send(2'b11, 2'd1);
      wait_idle();
      // Stuck-at-0 on bit 3: set reports mismatch, read reports no error
      stuck0 = 4'b1000;
      send(2'b01, 2'd3);
      wait_idle();
      send(2'b00, 2'd3);
      wait_idle();
      stuck0 = '0;

      // Reset during the first DRIVE cycle aborts the command
      @(posedge clk);
      #1;
      cmd_valid = 1'b1; cmd_op = 2'b01; cmd_idx = 2'd0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         if (acc_seen) break;
      end
      check_eq("abort_accept", acc_seen, 1);
      #1;
      cmd_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("abort_SR", {S, R}, 0);
      check_eq("abort_busy", busy, 0);
      wait_idle();
      send(2'b01, 2'd0);
      wait_idle();

      // Out-of-range index on the 3-bit bank
      @(posedge clk);
      #1;
      v2 = 1'b1; op2 = 2'b01; idx2 = 2'd3;
      @(negedge clk);
      check_eq("oor_ready", ready2, 1);
      @(posedge clk);
      #1 v2 = 1'b0;
      @(negedge clk);
      check_eq("oor_c1_rsp", {rv2, rq2, re2}, 3'b101);
      check_eq("oor_c1_SR", {S2, R2}, 0);
      check_eq("oor_c1_busy", busy2, 1);
      @(negedge clk);
      check_eq("oor_c2_rsp_valid", rv2, 0);
      check_eq("oor_c2_SR", {S2, R2}, 0);
      check_eq("oor_c2_ready", {busy2, ready2}, 2'b01);

      // Random stream, cmd_valid held high
      acc0 = n_acc;
      rsp0 = n_rsp;
      @(posedge clk);
      #1 cmd_valid = 1'b1;
      for (int c = 0; c < 3000 && (n_acc - acc0) < 200; c++) begin
         cmd_op  = 2'($urandom_range(0, 3));
         cmd_idx = 2'($urandom_range(0, 3));
         @(posedge clk);
         #1;
      end
      cmd_valid = 1'b0;
      check_eq("rand_accepts", n_acc - acc0, 200);
      wait_idle();
      check_eq("rand_rsp_count", n_rsp - rsp0, n_acc - acc0);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sr_ff_sequencer.md
Name: sr_ff_sequencer

Overview:
Command-driven controller for a bank of NUM_FF external clocked SR flip-flops. Accepts set, reset, toggle and read commands over a valid/ready port. Drives the addressed flip-flop's S or R input for a fixed pulse width, waits a settle interval, then reads back Q and reports the result. Guarantees the forbidden S=R=1 input combination is never driven on any bit.

Parameters:
NUM_FF, 4, number of SR flip-flops in the bank
IDX_W, 2, width of the command index; must satisfy 2^IDX_W >= NUM_FF
PULSE_CYCLES, 2, cycles S or R is held high per drive; minimum 1
SETTLE_CYCLES, 1, cycles with S=R=0 before readback; minimum 1

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  00=read, 01=set, 10=reset, 11=toggle
cmd_idx  input  IDX_W  flip-flop index
S  output  NUM_FF  set inputs to the flip-flop bank
R  output  NUM_FF  reset inputs to the flip-flop bank
Q  input  NUM_FF  Q outputs from the flip-flop bank
busy  output  1  high whenever state is not IDLE
rsp_valid  output  1  one-cycle response strobe
rsp_q  output  1  Q of the addressed bit sampled in CHECK
rsp_err  output  1  readback mismatch or index out of range

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; S=0, R=0, rsp_valid=0, rsp_q=0, rsp_err=0, busy=0. cmd_ready is 0 while rst=1.
- Reset mid-operation: S and R return to 0 at that edge. No response is emitted for the aborted command.
- cmd_ready = (state==IDLE) && !rst. A command is accepted at an edge where cmd_valid && cmd_ready. At that edge the controller latches op and idx, and samples Q[idx] for toggle.
- Outputs S, R, rsp_* and busy are registered.
- Out-of-range index (idx >= NUM_FF): no drive. The controller goes to CHECK at the next edge. In CHECK, rsp_valid=1, rsp_err=1, rsp_q=0.
- Expected value:
  - set -> expected 1
  - reset -> expected 0
  - toggle -> if the sampled Q=1, perform a reset (expected 0); otherwise perform a set (expected 1)
  - read -> skip DRIVE and SETTLE, go directly to CHECK; rsp_err=0
- States and transitions:
  - IDLE -> DRIVE on accept (set/reset/toggle)
  - IDLE -> CHECK on accept (read or out-of-range)
  - DRIVE lasts PULSE_CYCLES cycles: exactly one bit of S (set) or R (reset) is high, at position idx; all other bits are 0.
  - DRIVE -> SETTLE: S=R=0 for SETTLE_CYCLES cycles.
  - SETTLE -> CHECK: lasts one cycle; rsp_valid=1, rsp_q=Q[idx], rsp_err=(Q[idx] != expected) for drive ops.
  - CHECK -> IDLE.
- Latency, counted from the accept edge:
  - Drive ops: rsp_valid high in cycle PULSE_CYCLES+SETTLE_CYCLES+1 (cycle 4 with defaults).
  - Read: rsp_valid high in cycle 1.
  - cmd_ready returns high in the cycle after CHECK, so back-to-back drive throughput is one command per PULSE_CYCLES+SETTLE_CYCLES+2 cycles.
- Invariants, checked every cycle:
  - (S & R) == 0
  - popcount(S|R) <= 1
  - S|R == 0 outside DRIVE
- cmd_op and cmd_idx are ignored when no accept occurs. A change while busy has no effect.
- Pulse and settle counters are ceil(log2(max(PULSE_CYCLES,SETTLE_CYCLES)+1)) bits wide. They reload on each state entry and do not wrap.

Test Plan:
- Set (defaults, bank of SR flip-flop models, all Q=0): set idx=2 -> S=4'b0100 for 2 cycles then 0, R=0 throughout; rsp_valid in cycle 4 with rsp_q=1, rsp_err=0.
- Toggle twice on idx=1: first toggle drives S=4'b0010 and returns rsp_q=1; second drives R=4'b0010 and returns rsp_q=0; both rsp_err=0; cmd_ready low for cycles 1-4 of each command.
- Stuck fault: hold Q[3]=0 externally and set idx=3 -> rsp_q=0, rsp_err=1. Then read idx=3 -> rsp_valid in cycle 1 with rsp_err=0 and no S/R activity.
- Out-of-range: NUM_FF=3, IDX_W=2, set idx=3 -> S=R=0 always; rsp_valid in cycle 1 with rsp_err=1, rsp_q=0.
- Reset mid-drive: assert rst in cycle 1 of DRIVE -> S=R=0 next edge, busy=0, no rsp_valid; a new set command after rst deasserts completes normally.
- Randomised stream of 200 commands with cmd_valid held high -> the S/R invariants are never violated; every accepted command yields exactly one rsp_valid.
